// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit CPU control unit: opcode values, ALU
// operation encodings, sequencer state encoding and the decoded control
// bundle produced by cpu_decoder.
// No ports (package).
// ----------------------------------------------------------------------------
package cpu_pkg;

  // Opcodes, carried in INSTRUCTION[31:24]
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_LWD   = 8'h08;
  localparam logic [7:0] OP_SWD   = 8'h09;

  // ALU operation select
  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Sequencer states
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Decoded control bundle for one instruction
  typedef struct packed {
    logic [2:0] aluop;
    logic       imm_sel;    // immediate operand
    logic       sign_sel;   // negated register operand
    logic       wb_sel;     // write back memory data
    logic       reg_write;  // instruction ends in a register write
    logic       mem_read;   // lwd
    logic       mem_write;  // swd
    logic       jump;       // unconditional PC-relative jump
    logic       branch;     // conditional branch on ZERO
    logic       illegal;    // opcode not in the instruction set
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/cpu_decoder.sv
// ----------------------------------------------------------------------------
// cpu_decoder
// Purely combinational opcode decoder: maps the 8-bit opcode onto the control
// bundle used by the sequencer. Unknown opcodes return an all-zero bundle with
// only the illegal flag set.
// Ports:
//   opcode  in   8   instruction opcode (IR[31:24])
//   ctrl    out  ctrl_t decoded controls
// ----------------------------------------------------------------------------
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [7:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_NONE;
    case (opcode)
      OP_LOADI: begin
        ctrl.aluop     = ALU_FWD;
        ctrl.imm_sel   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_MOV: begin
        ctrl.aluop     = ALU_FWD;
        ctrl.reg_write = 1'b1;
      end
      OP_ADD: begin
        ctrl.aluop     = ALU_ADD;
        ctrl.reg_write = 1'b1;
      end
      OP_SUB: begin
        ctrl.aluop     = ALU_ADD;
        ctrl.sign_sel  = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_AND: begin
        ctrl.aluop     = ALU_AND;
        ctrl.reg_write = 1'b1;
      end
      OP_OR: begin
        ctrl.aluop     = ALU_OR;
        ctrl.reg_write = 1'b1;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      OP_BEQ: begin
        // Compare is a subtract: ZERO reports equality
        ctrl.aluop    = ALU_ADD;
        ctrl.sign_sel = 1'b1;
        ctrl.branch   = 1'b1;
      end
      OP_LWD: begin
        ctrl.aluop     = ALU_FWD;
        ctrl.wb_sel    = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_SWD: begin
        ctrl.aluop     = ALU_FWD;
        ctrl.mem_write = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// ----------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle control unit for the 8-bit CPU datapath. Owns the PC and IR,
// fetches over the instruction-memory busywait handshake and steps each
// instruction through FETCH -> DECODE -> EXEC -> (MEM) -> WB.
//
// Build option:
//   CPU_SEQ_ILLEGAL_TRAP_EN  defined   : unknown opcode halts the sequencer,
//                                        ILLEGAL sticks at 1 until reset.
//                            undefined : unknown opcode executes as a NOP.
//
// Handshakes: a memory request (IMEM_READ, DMEM_READ, DMEM_WRITE) is held
// high for as long as the matching BUSYWAIT is high; the transfer completes
// on the first rising CLK edge where the request is high and BUSYWAIT is low.
// Each BUSYWAIT is only looked at in the state that owns its request.
//
// Ports:
//   CLK            in   1         clock
//   RESET_N        in   1         asynchronous active-low reset
//   INSTRUCTION    in   32        instruction memory read data
//   IMEM_BUSYWAIT  in   1         instruction memory not ready
//   DMEM_BUSYWAIT  in   1         data memory access in progress
//   ZERO           in   1         ALU result is zero
//   PC             out  PC_WIDTH  address of the current instruction
//   IMEM_READ      out  1         instruction fetch request
//   ALUOP          out  3         ALU operation
//   IMM_SELECT     out  1         immediate operand select
//   SIGN_SELECT    out  1         negated register operand select
//   WRITEENABLE    out  1         register file write strobe
//   DMEM_READ      out  1         data memory read request
//   DMEM_WRITE     out  1         data memory write request
//   WB_SELECT      out  1         write back memory data
//   ILLEGAL        out  1         sticky unknown-opcode flag
//   DBG_STATE      out  state_t   current sequencer state (debug)
// ----------------------------------------------------------------------------
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int                     PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [31:0]         INSTRUCTION,
  input  logic                IMEM_BUSYWAIT,
  input  logic                DMEM_BUSYWAIT,
  input  logic                ZERO,
  output logic [PC_WIDTH-1:0] PC,
  output logic                IMEM_READ,
  output logic [2:0]          ALUOP,
  output logic                IMM_SELECT,
  output logic                SIGN_SELECT,
  output logic                WRITEENABLE,
  output logic                DMEM_READ,
  output logic                DMEM_WRITE,
  output logic                WB_SELECT,
  output logic                ILLEGAL,
  output state_t              DBG_STATE
);

  // Reset: asserts asynchronously, releases two edges after RESET_N rises
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n_int = rst_sync_q[1];

  // State, IR, PC and registered outputs
  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic                imem_read_q, imem_read_d;
  logic                we_q, we_d;
  logic                dmem_read_q, dmem_read_d;
  logic                dmem_write_q, dmem_write_d;
  logic                illegal_q, illegal_d;

  ctrl_t               dec_ctrl;

  cpu_decoder u_decoder (
    .opcode (ir_q[31:24]),
    .ctrl   (dec_ctrl)
  );

  // PC arithmetic: offset is a signed word count, scaled to bytes
  logic [7:0]          br_off;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] br_target;

  assign br_off    = ir_q[23:16];
  assign pc_plus4  = pc_q + PC_WIDTH'(4);
  assign br_target = pc_plus4 + {{(PC_WIDTH-10){br_off[7]}}, br_off, 2'b00};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;

    case (state_q)
      S_FETCH: begin
        // The request is registered, so the first cycle after reset only
        // raises IMEM_READ; data is accepted once the request is visible.
        if (imem_read_q && !IMEM_BUSYWAIT) begin
          ir_d    = INSTRUCTION;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl_d = dec_ctrl;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        if (dec_ctrl.illegal) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
`else
        state_d = S_EXEC;
`endif
      end
      S_EXEC: begin
        if (ctrl_q.jump) begin
          pc_d    = br_target;
          state_d = S_FETCH;
        end else if (ctrl_q.branch) begin
          pc_d    = ZERO ? br_target : pc_plus4;
          state_d = S_FETCH;
        end else if (ctrl_q.mem_read || ctrl_q.mem_write) begin
          state_d = S_MEM;
        end else if (ctrl_q.reg_write) begin
          state_d = S_WB;
        end else begin
          // Unknown opcode without the trap: fall through as a NOP
          pc_d    = pc_plus4;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (!DMEM_BUSYWAIT) begin
          if (ctrl_q.mem_read) begin
            state_d = S_WB;
          end else begin
            pc_d    = pc_plus4;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        pc_d    = pc_plus4;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Strobes are decoded from the next state so they come straight off
    // flops and line up exactly with the state they belong to.
    imem_read_d  = (state_d == S_FETCH);
    we_d         = (state_d == S_WB);
    dmem_read_d  = (state_d == S_MEM) && ctrl_d.mem_read;
    dmem_write_d = (state_d == S_MEM) && ctrl_d.mem_write;
  end

  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_VECTOR;
      ir_q         <= '0;
      ctrl_q       <= CTRL_NONE;
      imem_read_q  <= 1'b0;
      we_q         <= 1'b0;
      dmem_read_q  <= 1'b0;
      dmem_write_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ctrl_q       <= ctrl_d;
      imem_read_q  <= imem_read_d;
      we_q         <= we_d;
      dmem_read_q  <= dmem_read_d;
      dmem_write_q <= dmem_write_d;
      illegal_q    <= illegal_d;
    end
  end

  assign PC          = pc_q;
  assign IMEM_READ   = imem_read_q;
  assign ALUOP       = ctrl_q.aluop;
  assign IMM_SELECT  = ctrl_q.imm_sel;
  assign SIGN_SELECT = ctrl_q.sign_sel;
  assign WRITEENABLE = we_q;
  assign DMEM_READ   = dmem_read_q;
  assign DMEM_WRITE  = dmem_write_q;
  assign WB_SELECT   = ctrl_q.wb_sel;
  assign ILLEGAL     = illegal_q;
  assign DBG_STATE   = state_q;

  // IR[15:0] carries register fields for the datapath, not the sequencer
  logic unused_bits;
  assign unused_bits = ^{ir_q[15:0], ctrl_q.illegal, dec_ctrl.illegal};

endmodule
